fft_butterfly_stage: RTL and testbench

- Radix-2 DIT butterfly back end, directly downstream of the complex twiddle multiplier (`two16bitmult`).
- Takes the 64-bit complex product W·b in Q2.30 and rounds/saturates it to Q1.15.
- Time-aligns the product with the matching upper operand a, then produces x0 = a + W·b and x1 = a − W·b.
- Optional divide-by-2 scaling; counts butterflies per frame and reports per-frame overflow to the FFT controller.

---
 rtl/fft_butterfly_stage.sv | 131 +++++++++++++
 tb/tb_fft_butterfly_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_stage.sv
// fft_butterfly_stage: radix-2 DIT butterfly back end, rounds/saturates W*b to Q1.15, emits a+Wb / a-Wb.
// Define FFT_BFLY_ROUND_EN for round-half-up; without it every rounding step truncates.
module fft_butterfly_stage #(
    parameter int MULT_LAT       = 1,
    parameter int BFLY_PER_FRAME = 32,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] a_data,
    input  logic [63:0] prod,
    input  logic        scale_en,
    output logic        out_valid,
    output logic [31:0] x0,
    output logic [31:0] x1,
    output logic        frame_done,
    output logic        ovf_frame
);
`ifdef FFT_BFLY_ROUND_EN
    localparam logic RND = 1'b1;
`else
    localparam logic RND = 1'b0;
`endif
    typedef enum logic {IDLE, RUN} state_t;
    state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic r_scale, w_last, w_scale;
    logic [34:0] r_dl [MULT_LAT];
    logic [34:0] w_al;
    logic r_vr, r_lr, r_sr, r_satr, r_sticky, w_sat;
    logic [15:0] r_pr, r_pi, r_ar, r_ai;
    logic [16:0] w_pr, w_pi, w_sr, w_si, w_dr, w_di;

    // Results are {saturated, value}
    function automatic logic [16:0] sat16(input logic signed [32:0] s);
        return (s > 33'sd32767) ? {1'b1, 16'h7FFF} : (s < -33'sd32768) ? {1'b1, 16'h8000} : {1'b0, s[15:0]};
    endfunction

    function automatic logic [16:0] rnd_sat(input logic [31:0] p);
        return sat16(($signed({p[31], p}) + $signed({18'd0, RND, 14'd0})) >>> 15);
    endfunction

    function automatic logic [16:0] bfly(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic scl);
        logic signed [17:0] v;
        v = sub ? 18'($signed(a)) - 18'($signed(b)) : 18'($signed(a)) + 18'($signed(b));
        return sat16(33'(scl ? (v + $signed({17'd0, RND})) >>> 1 : v));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = in_valid ? (w_last ? IDLE : RUN) : r_state;
    end

    always_comb begin
        w_last  = r_cnt == CNT_W'(BFLY_PER_FRAME - 1);
        w_scale = (r_state == IDLE) ? scale_en : r_scale;
    end

    // Scale and last-of-frame travel with each sample so overlapping frames keep their own settings
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_scale <= 1'b0;
            for (int i = 0; i < MULT_LAT; i++) r_dl[i] <= '0;
        end else begin
            if (in_valid) r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (in_valid && r_state == IDLE) r_scale <= scale_en;
            r_dl[0] <= {in_valid, in_valid & w_last, w_scale, a_data};
            for (int i = 1; i < MULT_LAT; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    assign w_al = r_dl[MULT_LAT-1];
    assign w_pr = rnd_sat(prod[63:32]);
    assign w_pi = rnd_sat(prod[31:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vr   <= 1'b0;
            r_lr   <= 1'b0;
            r_sr   <= 1'b0;
            r_satr <= 1'b0;
            r_pr   <= '0;
            r_pi   <= '0;
            r_ar   <= '0;
            r_ai   <= '0;
        end else begin
            r_vr <= w_al[34];
            if (w_al[34]) begin
                r_lr   <= w_al[33];
                r_sr   <= w_al[32];
                r_ar   <= w_al[31:16];
                r_ai   <= w_al[15:0];
                r_pr   <= w_pr[15:0];
                r_pi   <= w_pi[15:0];
                r_satr <= w_pr[16] | w_pi[16];
            end
        end
    end

    assign w_sr  = bfly(r_ar, r_pr, 1'b0, r_sr);
    assign w_si  = bfly(r_ai, r_pi, 1'b0, r_sr);
    assign w_dr  = bfly(r_ar, r_pr, 1'b1, r_sr);
    assign w_di  = bfly(r_ai, r_pi, 1'b1, r_sr);
    assign w_sat = r_satr | w_sr[16] | w_si[16] | w_dr[16] | w_di[16];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            ovf_frame  <= 1'b0;
            r_sticky   <= 1'b0;
            x0         <= '0;
            x1         <= '0;
        end else begin
            out_valid  <= r_vr;
            frame_done <= r_vr & r_lr;
            if (r_vr) begin
                x0        <= {w_sr[15:0], w_si[15:0]};
                x1        <= {w_dr[15:0], w_di[15:0]};
                ovf_frame <= r_lr ? r_sticky | w_sat : ovf_frame;
                r_sticky  <= r_lr ? 1'b0 : r_sticky | w_sat;
            end
        end
    end
endmodule

// File: tb/tb_fft_butterfly_stage.sv
// tb_fft_butterfly_stage: randomized and directed stimulus against an arithmetic reference model.
module tb_fft_butterfly_stage;
    localparam int ML = 1, BPF = 32;
`ifdef FFT_BFLY_ROUND_EN
    localparam longint RND = 1;
`else
    localparam longint RND = 0;
`endif
    logic clk = 0, reset = 1, in_valid = 0, scale_en = 0;
    logic [31:0] a_data = 0;
    logic [63:0] prod, p_in = 0;
    logic out_valid, frame_done, ovf_frame;
    logic [31:0] x0, x1, first_x0 = 0, first_x1 = 0;
    logic [63:0] mp [ML];
    logic [31:0] corners [6] = '{32'h40000000, 32'hBFFFFFFF, 32'h3FFFC000, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000};
    int cyc = 0, checks = 0, errors = 0, last_push = 0;
    int fd_cnt = 0, ov_cnt = 0, first_ov = -1, last_fd = -1;
    typedef struct { int due; logic [31:0] x0, x1; logic fd, ovf; } exp_t;
    exp_t q[$];
    int m_idx = 0;
    logic m_scl = 0, m_acc = 0, exp_ovf = 0;

    fft_butterfly_stage #(.MULT_LAT(ML), .BFLY_PER_FRAME(BPF), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a_data(a_data), .prod(prod),
        .scale_en(scale_en), .out_valid(out_valid), .x0(x0), .x1(x1),
        .frame_done(frame_done), .ovf_frame(ovf_frame));

    always #5 clk = ~clk;

    // Stand-in for the twiddle multiplier: the product appears ML cycles after its operands
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mp[0] <= p_in;
        for (int i = 1; i < ML; i++) mp[i] <= mp[i-1];
    end
    assign prod = mp[ML-1];

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic longint clamp(longint v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    function automatic longint rnd(logic [31:0] p);
        return (longint'($signed(p)) + (RND << 14)) >>> 15;
    endfunction

    function automatic longint rs(logic [31:0] p);
        return clamp(rnd(p));
    endfunction

    task automatic push(logic [31:0] a, logic [63:0] p, logic sen);
        exp_t e;
        longint raw[2], pv[2], v, w, o;
        logic s;
        logic [15:0] r[4];
        s = 0;
        if (m_idx == 0) m_scl = sen;
        for (int k = 0; k < 2; k++) begin
            raw[k] = rnd(p[63-32*k -: 32]);
            pv[k] = clamp(raw[k]);
            s |= pv[k] != raw[k];
        end
        for (int k = 0; k < 4; k++) begin
            v = longint'($signed(a[31-16*(k%2) -: 16])) + ((k < 2) ? pv[k%2] : -pv[k%2]);
            w = m_scl ? (v + RND) >>> 1 : v;
            o = clamp(w);
            s |= o != w;
            r[k] = o[15:0];
        end
        m_acc |= s;
        e.due = cyc + ML + 2;
        e.x0 = {r[0], r[1]};
        e.x1 = {r[2], r[3]};
        e.fd = m_idx == BPF - 1;
        e.ovf = m_acc;
        if (e.fd) begin
            m_idx = 0;
            m_acc = 0;
        end else m_idx++;
        last_push = cyc;
        q.push_back(e);
    endtask

    function automatic logic [15:0] cv();
        return 16'(int'($urandom_range(0, 32766)) - 16383);
    endfunction

    function automatic logic [31:0] ra(logic clean);
        return clean ? {cv(), cv()} : $urandom;
    endfunction

    function automatic logic [31:0] rc(logic clean);
        if (clean) return 32'(int'($urandom_range(0, 32'h3FFFFFFF)) - 32'sh20000000);
        return ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
    endfunction

    task automatic drive(logic v, logic [31:0] a, logic [63:0] p, logic sen);
        @(negedge clk);
        in_valid = v;
        a_data = a;
        p_in = p;
        scale_en = sen;
        if (v) push(a, p, sen);
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, ra(0), {rc(0), rc(0)}, 1'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        in_valid = 0;
        q.delete();
        m_idx = 0;
        m_acc = 0;
        exp_ovf = 0;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic clr();
        fd_cnt = 0;
        ov_cnt = 0;
        first_ov = -1;
        last_fd = -1;
    endtask

    // gap: 0 back-to-back, 1 alternating, 2 random
    task automatic frame(int n, int gap, logic clean, logic [31:0] a0, logic [63:0] p0, logic sen0);
        for (int i = 0; i < n; i++) begin
            drive(1, i == 0 ? a0 : ra(clean), i == 0 ? p0 : {rc(clean), rc(clean)}, i == 0 ? sen0 : 1'($urandom));
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) idle(1);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                chk("reset_out_valid", 64'(out_valid), 0);
                chk("reset_x0", 64'(x0), 0);
                chk("reset_x1", 64'(x1), 0);
                chk("reset_frame_done", 64'(frame_done), 0);
                chk("reset_ovf_frame", 64'(ovf_frame), 0);
            end else begin
                if (out_valid) begin
                    ov_cnt++;
                    if (first_ov < 0) begin
                        first_ov = cyc;
                        first_x0 = x0;
                        first_x1 = x1;
                    end
                    if (q.size() == 0) fail("unexpected_out_valid");
                    else begin
                        e = q.pop_front();
                        chk("out_cycle", 64'(cyc), 64'(e.due));
                        chk("x0", 64'(x0), 64'(e.x0));
                        chk("x1", 64'(x1), 64'(e.x1));
                        chk("frame_done", 64'(frame_done), 64'(e.fd));
                        if (e.fd) exp_ovf = e.ovf;
                    end
                end else begin
                    chk("frame_done_idle", 64'(frame_done), 0);
                    if (q.size() > 0 && q[0].due <= cyc) begin
                        fail("missing_out_valid");
                        void'(q.pop_front());
                    end
                end
                if (frame_done) begin
                    fd_cnt++;
                    last_fd = cyc;
                end
                chk("ovf_frame", 64'(ovf_frame), 64'(exp_ovf));
            end
        end
    end

    initial begin
        int t0;
        chk("model_rs_round", 64'(rs(32'h1FFFC000)), RND ? 64'h4000 : 64'h3FFF);
        chk("model_rs_pos_sat", 64'(rs(32'h40000000)), 64'd32767);
        chk("model_rs_neg_sat", 64'(rs(32'hBFFFFFFF)), -64'sd32768);
        chk("model_rs_neg_round", 64'(rs(32'hFFFFC000)), RND ? 64'd0 : -64'sd1);
        do_reset();

        clr();
        drive(1, 32'h1000_0000, {32'h1FFFC000, 32'h0}, 0);
        idle(6);
        chk("basic_x0", 64'(first_x0), RND ? 64'h5000_0000 : 64'h4FFF_0000);
        chk("basic_x1", 64'(first_x1), RND ? 64'hD000_0000 : 64'hD001_0000);

        do_reset();
        clr();
        frame(1, 0, 1, ra(1), {rc(1), rc(1)}, 0);
        t0 = last_push;
        frame(BPF - 1, 0, 1, ra(1), {rc(1), rc(1)}, 0);
        idle(8);
        chk("stream_first_out", 64'(first_ov), 64'(t0 + ML + 2));
        chk("stream_frame_done_cycle", 64'(last_fd), 64'(t0 + ML + 2 + BPF - 1));
        chk("stream_frame_done_count", 64'(fd_cnt), 1);
        chk("stream_out_count", 64'(ov_cnt), BPF);
        chk("stream_ovf", 64'(ovf_frame), 0);

        clr();
        frame(BPF, 0, 1, 32'h7FFF_0000, {32'h40000000, 32'h0}, 0);
        idle(8);
        chk("sat_x0", 64'(first_x0), 64'h7FFF_0000);
        chk("sat_x1", 64'(first_x1), 64'h0000_0000);
        chk("sat_ovf", 64'(ovf_frame), 1);
        frame(BPF, 0, 1, ra(1), {rc(1), rc(1)}, 0);
        idle(8);
        chk("clean_after_sat_ovf", 64'(ovf_frame), 0);

        clr();
        frame(BPF, 0, 1, 32'h4000_0000, {32'h20000000, 32'h0}, 1);
        idle(8);
        chk("scale_x0", 64'(first_x0), 64'h4000_0000);
        chk("scale_x1", 64'(first_x1), 64'h0000_0000);

        clr();
        frame(10, 0, 0, ra(0), {rc(0), rc(0)}, 1);
        do_reset();
        idle(6);
        chk("partial_no_frame_done", 64'(fd_cnt), 0);
        frame(BPF, 0, 0, ra(0), {rc(0), rc(0)}, 0);
        idle(8);
        chk("fresh_frame_done_count", 64'(fd_cnt), 1);

        clr();
        frame(BPF, 1, 1, ra(1), {rc(1), rc(1)}, 1);
        idle(8);
        chk("gap_out_count", 64'(ov_cnt), BPF);
        chk("gap_frame_done_count", 64'(fd_cnt), 1);
        chk("gap_span", 64'(last_fd - first_ov), 64'(2 * (BPF - 1)));

        clr();
        for (int f = 0; f < 20; f++)
            frame(BPF, $urandom_range(0, 2), 1'($urandom_range(0, 1)), ra(0), {rc(0), rc(0)}, 1'($urandom));
        idle(10);
        chk("random_frame_done_count", 64'(fd_cnt), 20);
        chk("drain_empty", 64'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
